// File: rtl/ram_stream_reader_if.sv
// Command, status, RAM read port and output stream of the RAM stream reader.
// The slave modport is the reader's view; master is the controlling side.
interface ram_stream_reader_if #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 256
);
    localparam int AW = $clog2(ENTRIES);
    localparam int CW = AW + 1;

    logic             start;
    logic [AW-1:0]    start_addr;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic [AW-1:0]    ram_address;
    logic [WIDTH-1:0] ram_read_data;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  start, start_addr, count, ram_read_data, out_ready,
        output busy, done, ram_address, out_data, out_valid
    );

    modport master (
        output start, start_addr, count, ram_read_data, out_ready,
        input  busy, done, ram_address, out_data, out_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Sequential RAM read engine: walks a wrapping address run, hides the RAM's
// one-cycle read latency and streams words out through a 2-entry skid buffer.
//
// state | meaning
// IDLE  | waiting for start; command inputs sampled here only
// RUN   | issuing reads while words remain and the buffer has room
// DRAIN | all reads issued; waiting for buffer and in-flight read to empty
module ram_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_stream_reader_if.slave bus
);
    localparam int AW = $clog2(ENTRIES);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           rd_addr_q, rd_addr_d;
    logic [CW-1:0]           remaining_q, remaining_d;
    logic                    inflight_q, inflight_d;
    logic [1:0]              occ_q, occ_d;
    logic [1:0][WIDTH-1:0]   buf_q, buf_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;

    logic                    pop;
    logic                    issue;
    logic [2:0]              occ_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            occ_q       <= '0;
            buf_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            occ_q       <= occ_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        issue       = 1'b0;

        pop = (occ_q != 2'd0) && bus.out_ready;
        // Occupancy once the pending capture and this cycle's pop have landed;
        // a new read may only be issued if its word will still have a slot.
        occ_next = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rd_addr_d   = bus.start_addr;
                    remaining_d = bus.count;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (remaining_q == '0) begin
                    state_d = DRAIN;
                end else if (occ_next < 3'd2) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            rd_addr_d   = (rd_addr_q == AW'(ENTRIES - 1)) ? '0 : rd_addr_q + AW'(1);
            remaining_d = remaining_q - CW'(1);
        end
        inflight_d = issue;

        if (inflight_q) begin
            buf_d[wr_ptr_q] = bus.ram_read_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_next[1:0];
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DRAIN) && (occ_q == 2'd0) && !inflight_q;
    assign bus.ram_address = rd_addr_q;
    assign bus.out_valid   = (occ_q != 2'd0);
    assign bus.out_data    = buf_q[rd_ptr_q];
endmodule
